// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_adder_ctrl_pkg;

    // 2'b11 is unreachable and falls back to IDLE through the FSM default arm.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder slice built from two half_adder cells plus an OR of their carries.
// Latency: purely combinational.
// Backpressure: none.

// Gate-level half adder cell; port order is cout, sum, a, b.
module half_adder (
    output logic cout,
    output logic sum,
    input  logic a,
    input  logic b
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g0;
    logic g1;

    // First cell forms propagate/generate, second folds in the carry.
    half_adder u_ha0 (.cout(g0), .sum(p), .a(a),  .b(b));
    half_adder u_ha1 (.cout(g1), .sum(s), .a(p),  .b(ci));

    assign co = g0 | g1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder slice stepped LSB-first, one bit per clock.
// Latency: start accepted at edge 0, result registered at edge WIDTH, done high the cycle after.
// Backpressure: start ignored while busy; accepted in IDLE or DONE (back-to-back restart).
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] shs;
    logic             carry;
    logic             slice_s;
    logic             slice_co;
    logic             accept;
    logic             last_bit;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_adder_ctrl_fa u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = start    ? ST_RUN  : ST_IDLE;
            ST_RUN:  state_next = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_next = start    ? ST_RUN  : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, per-bit shifting and carry flop; result only updated on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            shs   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            shs   <= '0;
        end else if (state == ST_RUN) begin
            shs   <= {slice_s, shs[WIDTH-1:1]};
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= slice_co;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= {slice_s, shs[WIDTH-1:1]};
                cout <= slice_co;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
